boundary_scan_register: RTL and testbench

BOUNDARY_SCAN_REGISTER -- requirements
Module: boundary_scan_register

---
 rtl/boundary_scan_register.sv | 49 ++++
 tb/tb_boundary_scan_register.sv | 121 ++++++++++++
 2 files changed

// File: rtl/boundary_scan_register.sv
// boundary_scan_register: 4 input + 4 output boundary scan cells with capture/shift/update.
// Define BSR_SHIFT_CHECK_EN to add the shift-length counter driving len_err.
module boundary_scan_register (
  input  logic       clk,
  input  logic       TLR,
  input  logic       TDI,
  input  logic       select_bsr,
  input  logic       capture_dr,
  input  logic       shift_dr,
  input  logic       update_dr,
  input  logic       extest,
  input  logic [3:0] pin_in,
  output logic [3:0] X,
  input  logic [3:0] Yin,
  output logic [3:0] pin_out,
  output logic       TDO_bsr,
  output logic       len_err
);
  logic [7:0] shift_reg, update_reg;
  logic cap, shf, upd;
  // Illegal simultaneous strobes resolve as capture > shift > update
  assign cap = select_bsr & capture_dr;
  assign shf = select_bsr & shift_dr & ~capture_dr;
  assign upd = select_bsr & update_dr & ~capture_dr & ~shift_dr;
  always_ff @(posedge clk or posedge TLR)
    if (TLR) shift_reg <= '0;
    else if (cap) shift_reg <= {Yin, pin_in};
    else if (shf) shift_reg <= {TDI, shift_reg[7:1]};
  always_ff @(posedge clk or posedge TLR)
    if (TLR) update_reg <= '0;
    else if (upd) update_reg <= shift_reg;
`ifdef BSR_SHIFT_CHECK_EN
  logic [2:0] cnt;
  always_ff @(posedge clk or posedge TLR)
    if (TLR) begin
      cnt <= '0;
      len_err <= 1'b0;
    end else if (cap) begin
      cnt <= '0;
      len_err <= 1'b0;
    end else if (shf) cnt <= cnt + 3'd1;
    else if (upd && cnt != 3'd0) len_err <= 1'b1;
`else
  assign len_err = 1'b0;
`endif
  assign X = extest ? update_reg[3:0] : pin_in;
  assign pin_out = extest ? update_reg[7:4] : Yin;
  assign TDO_bsr = shift_reg[0];
endmodule

// File: tb/tb_boundary_scan_register.sv
// tb_boundary_scan_register: directed and randomized checks against a behavioural scan-chain model.
module tb_boundary_scan_register;
  logic clk = 0, TLR = 1, TDI = 0, select_bsr = 0, capture_dr = 0, shift_dr = 0, update_dr = 0, extest = 0;
  logic [3:0] pin_in = 0, Yin = 0, X, pin_out;
  logic TDO_bsr, len_err;
  int tests = 0, errs = 0;
  int msr = 0, mur = 0, mcnt = 0, merr = 0;
  boundary_scan_register dut (
    .clk(clk), .TLR(TLR), .TDI(TDI), .select_bsr(select_bsr), .capture_dr(capture_dr),
    .shift_dr(shift_dr), .update_dr(update_dr), .extest(extest), .pin_in(pin_in), .X(X),
    .Yin(Yin), .pin_out(pin_out), .TDO_bsr(TDO_bsr), .len_err(len_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_outs(input string tag);
    int ex, ep, el;
    ex = extest ? (mur % 16) : pin_in;
    ep = extest ? (mur / 16) : Yin;
`ifdef BSR_SHIFT_CHECK_EN
    el = merr;
`else
    el = 0;
`endif
    chk({tag, "_X"}, {4'b0, X}, ex[7:0]);
    chk({tag, "_pin_out"}, {4'b0, pin_out}, ep[7:0]);
    chk({tag, "_TDO"}, {7'b0, TDO_bsr}, 8'(msr % 2));
    chk({tag, "_len_err"}, {7'b0, len_err}, el[7:0]);
  endtask
  task automatic model_reset();
    msr = 0; mur = 0; mcnt = 0; merr = 0;
  endtask
  // Called at a negedge: apply strobes for one rising edge, then check at the next negedge
  task automatic step(input string tag, input logic c, input logic s, input logic u, input logic d);
    capture_dr = c; shift_dr = s; update_dr = u; TDI = d;
    @(posedge clk);
    if (select_bsr && c) begin
      msr = Yin * 16 + pin_in; mcnt = 0; merr = 0;
    end else if (select_bsr && s) begin
      msr = msr / 2 + d * 128; mcnt = (mcnt + 1) % 8;
    end else if (select_bsr && u) begin
      mur = msr;
      if (mcnt != 0) merr = 1;
    end
    @(negedge clk);
    capture_dr = 0; shift_dr = 0; update_dr = 0;
    check_outs(tag);
  endtask
  initial begin
    logic [7:0] seq, pat;
    @(negedge clk);
    extest = 1;
    #1 check_outs("reset");
    TLR = 0;
    select_bsr = 1;
    for (int i = 0; i < 8; i++) step("fill", 0, 1, 0, 1);
    step("upd_ff", 0, 0, 1, 0);
    chk("ff_X", {4'b0, X}, 8'h0F);
    #2 TLR = 1;
    model_reset();
    #1 chk("rst_X", {4'b0, X}, 8'h00);
    chk("rst_pin_out", {4'b0, pin_out}, 8'h00);
    chk("rst_TDO", {7'b0, TDO_bsr}, 8'h00);
    @(negedge clk);
    TLR = 0;
    extest = 0;
    pin_in = 4'b1010; Yin = 4'b0110;
    step("cap", 1, 0, 0, 0);
    seq = 8'b0110_1010;
    for (int i = 0; i < 8; i++) begin
      chk("tdo_seq", {7'b0, TDO_bsr}, {7'b0, seq[i]});
      step("shift0", 0, 1, 0, 0);
    end
    pat = 8'b1100_0101;
    for (int i = 0; i < 8; i++) step("shiftp", 0, 1, 0, pat[i]);
    extest = 1;
    step("extest_upd", 0, 0, 1, 0);
    chk("extest_X", {4'b0, X}, 8'h05);
    chk("extest_pin_out", {4'b0, pin_out}, 8'h0C);
    extest = 0; pin_in = 4'b0011; Yin = 4'b1001;
    #1 chk("transp_X", {4'b0, X}, 8'h03);
    chk("transp_pin_out", {4'b0, pin_out}, 8'h09);
    extest = 1;
    #1 chk("toggle_X", {4'b0, X}, 8'h05);
    chk("toggle_pin_out", {4'b0, pin_out}, 8'h0C);
    select_bsr = 0;
    step("desel_cap", 1, 0, 0, 1);
    step("desel_shift", 0, 1, 0, 1);
    step("desel_upd", 0, 0, 1, 1);
    select_bsr = 1;
    step("cap5", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("shift5", 0, 1, 0, 1);
    step("upd5", 0, 0, 1, 0);
    step("cap8", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("shift8", 0, 1, 0, 0);
    step("upd8", 0, 0, 1, 0);
    for (int n = 0; n < 400; n++) begin
      logic [2:0] st;
      select_bsr = ($urandom_range(0, 7) != 0);
      extest = 1'($urandom);
      pin_in = 4'($urandom);
      Yin = 4'($urandom);
      st = 3'($urandom_range(0, 15) == 0 ? $urandom : (1 << $urandom_range(0, 2)) & {3{$urandom_range(0, 3) != 0}});
      if ($urandom_range(0, 39) == 0) begin
        #2 TLR = 1;
        model_reset();
        #1 check_outs("rnd_rst");
        #1 TLR = 0;
        @(negedge clk);
      end
      step("rnd", st[0], st[1], st[2], 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
